// File: rtl/pll_cfg_pkg.sv
// Shared types and register map for the PLL configuration sequencer.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        LOAD    = 3'd1,
        ACQUIRE = 3'd2,
        LOCKED  = 3'd3,
        QUIESCE = 3'd4,
        FAULT   = 3'd5
    } chan_state_t;

    localparam logic [7:0] CH_STRIDE = 8'h20;

    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_KP     = 5'h04;
    localparam logic [4:0] REG_KI     = 5'h08;
    localparam logic [4:0] REG_N      = 5'h0C;
    localparam logic [4:0] REG_STATUS = 5'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_APPLY  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_LOCKED    = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_FAULT     = 2;
    localparam int ST_LOST      = 3;
    localparam int ST_STATE_LSB = 4;

    localparam logic [31:0] ST_W1C_MASK = 32'h0000_000C;

endpackage

// File: rtl/pll_chan_seq.sv
// One PLL channel: lock synchroniser, shadow/active gains, sticky status
// and the off/load/acquire/locked/quiesce/fault sequencer.
module pll_chan_seq
    import pll_cfg_pkg::*;
#(
    parameter int KP_W        = 16,
    parameter int KI_W        = 16,
    parameter int N_W         = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int LOCK_CYC    = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_i,
    input  logic [4:0]      off_i,
    input  logic [31:0]     wdata_i,
    input  logic            lock_raw_i,
    output logic [31:0]     rdata_o,
    output logic            pll_enable_o,
    output logic [KP_W-1:0] kp_o,
    output logic [KI_W-1:0] ki_o,
    output logic [N_W-1:0]  n_o,
    output logic            irq_req_o
);

    localparam int LCW = $clog2(LOCK_CYC) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYC) + 1;
    localparam int SCW = $clog2(SETTLE_CYC) + 1;

    localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_CYC);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYC - 1);
    localparam logic [TCW-1:0] TO_MAX    = TCW'(TIMEOUT_CYC);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYC - 1);
    // The load cycle also holds the PLL off, so quiesce is one cycle shorter.
    localparam int             Q_LAST    = (SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0;
    localparam logic [SCW-1:0] SET_LAST  = SCW'(Q_LAST);
    localparam chan_state_t    APPLY_TGT = (SETTLE_CYC >= 2) ? QUIESCE : LOAD;

    chan_state_t      state_q, state_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic [KP_W-1:0]  kp_sh_q, kp_sh_d, kp_q, kp_d;
    logic [KI_W-1:0]  ki_sh_q, ki_sh_d, ki_q, ki_d;
    logic [N_W-1:0]   n_sh_q, n_sh_d, n_q, n_d;
    logic             sync1_q, lock_q;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [TCW-1:0]   to_cnt_q, to_cnt_d;
    logic [SCW-1:0]   set_cnt_q, set_cnt_d;
    logic             fault_q, fault_d, lost_q, lost_d;
    logic             wr_ctrl, wr_st, apply, load;
    logic             fault_set, lost_set;
    logic [31:0]      status;
    logic             unused_wd;

    assign wr_ctrl   = wr_i && (off_i == REG_CTRL);
    assign wr_st     = wr_i && (off_i == REG_STATUS);
    assign apply     = wr_ctrl && wdata_i[CTRL_APPLY];
    assign unused_wd = ^wdata_i;

    always_comb begin
        en_d       = wr_ctrl ? wdata_i[CTRL_EN] : en_q;
        irq_en_d   = wr_ctrl ? wdata_i[CTRL_IRQ_EN] : irq_en_q;
        kp_sh_d    = (wr_i && off_i == REG_KP) ? wdata_i[KP_W-1:0] : kp_sh_q;
        ki_sh_d    = (wr_i && off_i == REG_KI) ? wdata_i[KI_W-1:0] : ki_sh_q;
        n_sh_d     = (wr_i && off_i == REG_N) ? wdata_i[N_W-1:0] : n_sh_q;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        to_cnt_d   = to_cnt_q;
        set_cnt_d  = set_cnt_q;
        load       = 1'b0;
        fault_set  = 1'b0;
        lost_set   = 1'b0;
        if (!en_d) begin
            state_d = OFF;
            load    = (state_q == OFF) && apply;
        end else begin
            unique case (state_q)
                OFF: state_d = LOAD;
                LOAD: begin
                    load       = 1'b1;
                    lock_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (apply) begin
                        set_cnt_d = '0;
                        state_d   = APPLY_TGT;
                    end else begin
                        if (!lock_q)
                            lock_cnt_d = '0;
                        else if (lock_cnt_q != LOCK_MAX)
                            lock_cnt_d = lock_cnt_q + LCW'(1);
                        if (to_cnt_q != TO_MAX)
                            to_cnt_d = to_cnt_q + TCW'(1);
                        if (lock_q && lock_cnt_q >= LOCK_LAST) begin
                            state_d = LOCKED;
                        end else if (to_cnt_q >= TO_LAST) begin
                            state_d   = FAULT;
                            fault_set = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (apply) begin
                        set_cnt_d = '0;
                        state_d   = APPLY_TGT;
                    end else if (!lock_q) begin
                        lock_cnt_d = '0;
                        to_cnt_d   = '0;
                        lost_set   = 1'b1;
                        state_d    = ACQUIRE;
                    end
                end
                QUIESCE: begin
                    if (set_cnt_q >= SET_LAST)
                        state_d = LOAD;
                    else
                        set_cnt_d = set_cnt_q + SCW'(1);
                end
                FAULT: if (apply) state_d = LOAD;
                default: state_d = OFF;
            endcase
        end
        kp_d    = load ? kp_sh_q : kp_q;
        ki_d    = load ? ki_sh_q : ki_q;
        n_d     = load ? n_sh_q : n_q;
        // A hardware set beats a same-cycle clear.
        fault_d = fault_set | (fault_q & ~(wr_st & wdata_i[ST_FAULT]));
        lost_d  = lost_set | (lost_q & ~(wr_st & wdata_i[ST_LOST]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OFF;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            kp_sh_q    <= '0;
            ki_sh_q    <= '0;
            n_sh_q     <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            n_q        <= '0;
            sync1_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
            to_cnt_q   <= '0;
            set_cnt_q  <= '0;
            fault_q    <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            kp_sh_q    <= kp_sh_d;
            ki_sh_q    <= ki_sh_d;
            n_sh_q     <= n_sh_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            n_q        <= n_d;
            sync1_q    <= lock_raw_i;
            lock_q     <= sync1_q;
            lock_cnt_q <= lock_cnt_d;
            to_cnt_q   <= to_cnt_d;
            set_cnt_q  <= set_cnt_d;
            fault_q    <= fault_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        status                      = '0;
        status[ST_LOCKED]           = (state_q == LOCKED);
        status[ST_BUSY]             = state_q inside {QUIESCE, LOAD, ACQUIRE};
        status[ST_FAULT]            = fault_q;
        status[ST_LOST]             = lost_q;
        status[ST_STATE_LSB +: 3]   = state_q;
        rdata_o = '0;
        case (off_i)
            REG_CTRL: begin
                rdata_o[CTRL_EN]     = en_q;
                rdata_o[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_KP:     rdata_o = 32'(kp_sh_q);
            REG_KI:     rdata_o = 32'(ki_sh_q);
            REG_N:      rdata_o = 32'(n_sh_q);
            REG_STATUS: rdata_o = status;
            default:    rdata_o = '0;
        endcase
    end

    assign pll_enable_o = (state_q == ACQUIRE) || (state_q == LOCKED);
    assign kp_o         = kp_q;
    assign ki_o         = ki_q;
    assign n_o          = n_q;
    assign irq_req_o    = irq_en_q & (fault_q | lost_q);

endmodule

// File: rtl/pll_cfg_seq.sv
// Register front end for N_CH PLL channel sequencers: address decode,
// access errors, read mux and the shared interrupt.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int KP_W        = 16,
    parameter int KI_W        = 16,
    parameter int N_W         = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int LOCK_CYC    = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [7:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 error,
    input  logic [N_CH-1:0]      pll_lock_raw,
    output logic [N_CH-1:0]      pll_enable,
    output logic [N_CH*KP_W-1:0] kp,
    output logic [N_CH*KI_W-1:0] ki,
    output logic [N_CH*N_W-1:0]  n,
    output logic                 irq
);

    logic [2:0]      ch;
    logic [4:0]      off;
    logic            bad;
    logic [31:0]     rd_ch [N_CH];
    logic [N_CH-1:0] irq_req;
    logic            irq_q;

    assign ch  = addr[7:5];
    assign off = addr[4:0];

    always_comb begin
        bad = (addr[1:0] != 2'b00) ||
              (int'(ch) >= N_CH) ||
              (off > REG_STATUS) ||
              (wen && off == REG_STATUS && (wdata & ~ST_W1C_MASK) != '0);
        error = (wen || ren) && bad;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pll_chan_seq #(
            .KP_W        (KP_W),
            .KI_W        (KI_W),
            .N_W         (N_W),
            .SETTLE_CYC  (SETTLE_CYC),
            .LOCK_CYC    (LOCK_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .wr_i         (wen && !bad && ch == 3'(c)),
            .off_i        (off),
            .wdata_i      (wdata),
            .lock_raw_i   (pll_lock_raw[c]),
            .rdata_o      (rd_ch[c]),
            .pll_enable_o (pll_enable[c]),
            .kp_o         (kp[c*KP_W +: KP_W]),
            .ki_o         (ki[c*KI_W +: KI_W]),
            .n_o          (n[c*N_W +: N_W]),
            .irq_req_o    (irq_req[c])
        );
    end

    always_comb begin
        rdata = '0;
        if (ren && !bad) begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(ch) == c)
                    rdata = rd_ch[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_q <= 1'b0;
        else
            irq_q <= |irq_req;
    end

    assign irq = irq_q;

endmodule
